// File: rtl/button_pkg.sv
// Shared definitions for the pushbutton conditioner: FSM state encoding and default timing.
package button_pkg;

    localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = 4;
    localparam int unsigned DEFAULT_LONG_CYCLES     = 16;
    localparam int unsigned COUNT_W                 = 6;

    typedef enum logic [1:0] {
        ST_RELEASED        = 2'd0,
        ST_CONFIRM_PRESS   = 2'd1,
        ST_PRESSED         = 2'd2,
        ST_CONFIRM_RELEASE = 2'd3
    } state_t;

    // Debounced level is high once a press has been accepted until its release is accepted.
    function automatic logic is_level(input state_t s);
        return (s == ST_PRESSED) || (s == ST_CONFIRM_RELEASE);
    endfunction

    function automatic logic is_busy(input state_t s);
        return (s == ST_CONFIRM_PRESS) || (s == ST_CONFIRM_RELEASE);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for an asynchronous single-bit input.
module sync_2ff (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (reset) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/button_conditioner.sv
// Pushbutton debouncer with press/release/long-press strobes and a wrapping press counter.
module button_conditioner
    import button_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int unsigned LONG_CYCLES     = DEFAULT_LONG_CYCLES
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               btn_in,
    input  logic               count_clear,
    output logic               btn_level,
    output logic               press_pulse,
    output logic               release_pulse,
    output logic               long_pulse,
    output logic [COUNT_W-1:0] press_count,
    output logic               busy
);

    localparam int unsigned STABLE_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int unsigned HOLD_W   = $clog2(LONG_CYCLES + 1);

    localparam logic [STABLE_W-1:0] STABLE_LAST = STABLE_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HOLD_W-1:0]   HOLD_MAX    = HOLD_W'(LONG_CYCLES);
    localparam logic [HOLD_W-1:0]   HOLD_LONG   = HOLD_W'(LONG_CYCLES - 1);

    logic                btn_sync;
    state_t              state_q, state_d;
    logic [STABLE_W-1:0] stable_q, stable_d;
    logic [HOLD_W-1:0]   hold_q, hold_d;
    logic                press_c, release_c, long_c;

    sync_2ff u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (btn_in),
        .q     (btn_sync)
    );

    // State and counter registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_RELEASED;
            stable_q <= '0;
            hold_q   <= '0;
        end else begin
            state_q  <= state_d;
            stable_q <= stable_d;
            hold_q   <= hold_d;
        end
    end

    // Next-state, counter and strobe decisions
    always_comb begin
        state_d   = state_q;
        stable_d  = stable_q;
        hold_d    = hold_q;
        press_c   = 1'b0;
        release_c = 1'b0;

        case (state_q)
            ST_RELEASED: begin
                stable_d = '0;
                if (btn_sync) begin
                    state_d  = ST_CONFIRM_PRESS;
                    stable_d = STABLE_W'(1);
                end
            end
            ST_CONFIRM_PRESS: begin
                if (!btn_sync) begin
                    state_d  = ST_RELEASED;
                    stable_d = '0;
                end else if (stable_q == STABLE_LAST) begin
                    state_d  = ST_PRESSED;
                    stable_d = '0;
                    hold_d   = '0;
                    press_c  = 1'b1;
                end else begin
                    stable_d = stable_q + STABLE_W'(1);
                end
            end
            ST_PRESSED: begin
                if (!btn_sync) begin
                    state_d  = ST_CONFIRM_RELEASE;
                    stable_d = STABLE_W'(1);
                end else if (hold_q != HOLD_MAX) begin
                    hold_d = hold_q + HOLD_W'(1);
                end
            end
            ST_CONFIRM_RELEASE: begin
                if (btn_sync) begin
                    state_d  = ST_PRESSED;
                    stable_d = '0;
                end else if (stable_q == STABLE_LAST) begin
                    state_d   = ST_RELEASED;
                    stable_d  = '0;
                    release_c = 1'b1;
                end else begin
                    stable_d = stable_q + STABLE_W'(1);
                end
            end
            default: begin
                state_d  = ST_RELEASED;
                stable_d = '0;
            end
        endcase

        // Hold counter only moves upward and saturates past LONG-1, so this fires once per press
        long_c = (hold_d == HOLD_LONG) && (hold_q != HOLD_LONG);
    end

    // Registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            btn_level     <= 1'b0;
            busy          <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            long_pulse    <= 1'b0;
            press_count   <= '0;
        end else begin
            btn_level     <= is_level(state_d);
            busy          <= is_busy(state_d);
            press_pulse   <= press_c;
            release_pulse <= release_c;
            long_pulse    <= long_c;
            if (count_clear) begin
                press_count <= '0;
            end else if (press_c) begin
                press_count <= press_count + COUNT_W'(1);
            end
        end
    end

endmodule

// File: doc/button_conditioner.md
BUTTON_CONDITIONER -- requirements
Module: button_conditioner

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 4: consecutive stable synchronized samples required to accept a level change; legal range 2..255.
REQ-002 Parameter LONG_CYCLES, default 16: cycles a press is held before long_pulse; legal range 2..65535.
REQ-003 Port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 Port reset  input  1  synchronous, active-high reset.
REQ-005 Port btn_in  input  1  raw asynchronous pushbutton/switch level; 1 means pressed.
REQ-006 Port count_clear  input  1  synchronous clear of press_count.
REQ-007 Port btn_level  output  1  debounced level: 1 in PRESSED and CONFIRM_RELEASE.
REQ-008 Port press_pulse  output  1  one-cycle strobe on accepted press.
REQ-009 Port release_pulse  output  1  one-cycle strobe on accepted release.
REQ-010 Port long_pulse  output  1  one-cycle strobe when a press reaches LONG_CYCLES.
REQ-011 Port press_count  output  6  accepted presses modulo 64; drives the six-LED display stage.
REQ-012 Port busy  output  1  1 while in CONFIRM_PRESS or CONFIRM_RELEASE.

Function
REQ-013 btn_in SHALL pass through a two-flop synchronizer; the FSM SHALL see only the second-flop output (btn_sync).
REQ-014 FSM states SHALL be RELEASED, CONFIRM_PRESS, PRESSED, CONFIRM_RELEASE.
REQ-015 RELEASED: btn_sync=1 -> CONFIRM_PRESS with stable counter=1; else stay.
REQ-016 CONFIRM_PRESS: btn_sync=0 -> RELEASED, counter=0 (glitch rejected, no pulse); counter=DEBOUNCE_CYCLES-1 with btn_sync=1 -> PRESSED; else counter+1.
REQ-017 PRESSED: btn_sync=0 -> CONFIRM_RELEASE with counter=1; else stay, hold counter+1, saturating at LONG_CYCLES.
REQ-018 CONFIRM_RELEASE: btn_sync=1 -> PRESSED (hold counter retained); counter=DEBOUNCE_CYCLES-1 with btn_sync=0 -> RELEASED; else counter+1.
REQ-019 Latency: if btn_in is first sampled 1 at edge k and held, press_pulse SHALL be 1 exactly for the cycle after edge k+DEBOUNCE_CYCLES+1; release latency identical.
REQ-020 btn_in high for fewer than DEBOUNCE_CYCLES consecutive sampling edges SHALL produce no pulse and no count change.
REQ-021 press_pulse, release_pulse, long_pulse SHALL be registered and never high two consecutive cycles.
REQ-022 Hold counter SHALL clear on entry to PRESSED from CONFIRM_PRESS; long_pulse SHALL fire once per press when it reaches LONG_CYCLES-1, never re-firing until the next accepted press.
REQ-023 press_count SHALL increment on the edge that raises press_pulse, wrapping 63 -> 0.
REQ-024 count_clear and a press in the same cycle: clear wins, press_count=0.
REQ-025 All outputs SHALL be registered; no combinational path from btn_in to any output.

Reset
REQ-026 reset=1 at a rising edge SHALL force state RELEASED, synchronizer flops 0, all counters 0, every output 0, regardless of state.
REQ-027 Reset mid-confirm or mid-press SHALL emit no pulse; a still-held button after reset SHALL be re-debounced from RELEASED and counted as a new press.

Structure
REQ-028 Shared package button_pkg SHALL hold the state encoding (2-bit) and the default DEBOUNCE_CYCLES/LONG_CYCLES values.
REQ-029 Synchronizer SHALL be sub-module sync_2ff (clk, reset, d, q), reusable for other external inputs.
REQ-030 Target size 120-400 lines RTL; counters sized by clog2 of their parameter.

Verification
REQ-031 Defaults; btn_in=1 held from edge 0 -> press_pulse high only after edge 5, press_count=1, btn_level=1 from same edge.
REQ-032 btn_in toggled every cycle for 64 cycles (bouncing) -> no pulses, press_count=0, busy toggles, btn_level=0.
REQ-033 Hold btn_in=1 40 cycles -> exactly one press_pulse, one long_pulse 15 cycles after press_pulse, then release -> one release_pulse 5 edges after btn_in falls.
REQ-034 65 clean presses -> press_count=1 (wrap through 63 -> 0); count_clear with 66th press pulse cycle -> press_count=0.
REQ-035 reset asserted in CONFIRM_PRESS and in PRESSED with btn_in held -> all outputs 0 next cycle; after release of reset, new press_pulse after 5 edges, press_count=1.
